// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_WORDS = 4;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_line_fill_if.sv
// Fetch-port and line-SRAM signals of the instruction cache; master is the cache side.
interface icache_line_fill_if #(
  parameter int MA_W = 12
);

  logic                cpu_req_i;
  logic [31:0]         cpu_addr_i;
  logic                cpu_valid_o;
  logic [31:0]         cpu_data_o;
  logic                mem_re_o;
  logic                mem_we_o;
  logic [3:0]          mem_ble_o;
  logic [MA_W-1:0]     mem_add_o;
  logic                mem_valid_i;
  icache_pkg::line_t   mem_d_i;

  modport master (
    input  cpu_req_i, cpu_addr_i, mem_valid_i, mem_d_i,
    output cpu_valid_o, cpu_data_o, mem_re_o, mem_we_o, mem_ble_o, mem_add_o
  );

  modport slave (
    output cpu_req_i, cpu_addr_i, mem_valid_i, mem_d_i,
    input  cpu_valid_o, cpu_data_o, mem_re_o, mem_we_o, mem_ble_o, mem_add_o
  );

endinterface

// File: rtl/icache_tag_store.sv
// Per-line valid/tag/data storage: asynchronous read, one line written per cycle,
// and a single-cycle clear of every valid bit.
module icache_tag_store
  import icache_pkg::*;
#(
  parameter int NB_LINES = 16,
  parameter int TAG_W    = 6,
  localparam int IDX_W   = $clog2(NB_LINES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line,
  input  logic             clear_all
);

  logic [NB_LINES-1:0] valid_reg;
  logic [NB_LINES-1:0] line_we;
  logic [TAG_W-1:0]    tag_reg  [NB_LINES];
  line_t               data_reg [NB_LINES];

  for (genvar gi = 0; gi < NB_LINES; gi++) begin : g_we
    assign line_we[gi] = wr_en && (wr_idx == IDX_W'(gi));
  end

  // Clear wins over a same-cycle install, so a flush pending during a fill
  // leaves the freshly written line invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
    end else if (clear_all) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | line_we;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB_LINES; i++) begin
      if (line_we[i]) begin
        tag_reg[i]  <= wr_tag;
        data_reg[i] <= wr_line;
      end
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_reg[rd_idx];
  assign rd_line  = data_reg[rd_idx];

endmodule

// File: rtl/icache_line_fill.sv
// Direct-mapped read-only instruction cache: combinational hits, one 4-word
// line refill from the SRAM per miss, flush-all and hit/miss counters.
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int MEM_SIZE = 4096,
  parameter int NB_LINES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  icache_line_fill_if.master  bus,
  input  logic                flush_i,
  output logic [15:0]         hit_cnt_o,
  output logic [15:0]         miss_cnt_o
);

  localparam int MA_W  = $clog2(MEM_SIZE);
  localparam int IDX_W = $clog2(NB_LINES);
  localparam int TAG_W = MA_W - IDX_W - 2;

  logic [MA_W-1:0]  word_addr;
  logic [1:0]       offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;

  state_e      state_reg, state_next;
  logic        flush_pend_reg, flush_pend_next;
  logic [15:0] hit_cnt_reg, miss_cnt_reg;

  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  line_t            line_data;
  logic             hit, miss, fill_done, flush_all;

  assign word_addr        = bus.cpu_addr_i[MA_W+1:2];
  assign offset           = word_addr[1:0];
  assign index            = word_addr[IDX_W+1:2];
  assign tag              = word_addr[MA_W-1:IDX_W+2];
  assign unused_addr_bits = ^{bus.cpu_addr_i[31:MA_W+2], bus.cpu_addr_i[1:0]};

  icache_tag_store #(
    .NB_LINES (NB_LINES),
    .TAG_W    (TAG_W)
  ) u_tag_store (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_idx    (index),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_line   (line_data),
    .wr_en     (fill_done),
    .wr_idx    (index),
    .wr_tag    (tag),
    .wr_line   (bus.mem_d_i),
    .clear_all (flush_all)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      flush_pend_reg <= 1'b0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      flush_pend_reg <= flush_pend_next;
      hit_cnt_reg    <= hit_cnt_reg + 16'(hit);
      miss_cnt_reg   <= miss_cnt_reg + 16'(miss);
    end
  end

  always_comb begin
    state_next      = state_reg;
    flush_pend_next = flush_pend_reg;
    hit             = 1'b0;
    miss            = 1'b0;
    fill_done       = 1'b0;
    flush_all       = 1'b0;
    case (state_reg)
      IDLE: begin
        hit       = bus.cpu_req_i && line_valid && (line_tag == tag);
        flush_all = flush_i;
        if (bus.cpu_req_i && !hit) begin
          miss       = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (flush_i) flush_pend_next = 1'b1;
        // A flush seen at any point of the fill also discards the line just fetched.
        if (bus.mem_valid_i) begin
          fill_done       = 1'b1;
          flush_all       = flush_pend_reg || flush_i;
          flush_pend_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cpu_valid_o = hit;
  assign bus.cpu_data_o  = hit ? line_data[offset] : 32'h0;
  assign bus.mem_re_o    = (state_reg == FILL);
  assign bus.mem_we_o    = 1'b0;
  assign bus.mem_ble_o   = 4'hF;
  assign bus.mem_add_o   = {tag, index, 2'b00};
  assign hit_cnt_o       = hit_cnt_reg;
  assign miss_cnt_o      = miss_cnt_reg;

endmodule
